// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the staged reset sequencer:
//   - sequencer state encoding (HOLD / RELEASE / DONE)
//   - reset cause codes reported when RST_CAUSE_EN is defined
//   - legal parameter ranges, checked at elaboration by the top
//   - cnt_width(): $clog2 clamped to a minimum of one bit
// -----------------------------------------------------------------------------
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_RST  = 2'b00,
        CAUSE_EXT  = 2'b01,
        CAUSE_SW   = 2'b10,
        CAUSE_BOTH = 2'b11
    } cause_e;

    localparam int NUM_OUT_MIN     = 1;
    localparam int NUM_OUT_MAX     = 8;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int STRETCH_MIN     = 1;
    localparam int STRETCH_MAX     = 65535;
    localparam int STAGE_DELAY_MAX = 255;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Request inputs and staged reset outputs of one reset_sequencer.
//   extReqIn   : asynchronous level reset request, active-high
//   swReqIn    : synchronous software reset pulse, active-high
//   rstOut     : NUM_OUT staged resets, bit 0 releases first
//   rstDoneOut : high once every rstOut bit is released
//   causeOut   : cause of the last HOLD entry (only with RST_CAUSE_EN)
// Modports: master = request source / reset consumer, slave = sequencer.
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int NUM_OUT = 3
);
    import reset_sequencer_pkg::*;

    logic               extReqIn;
    logic               swReqIn;
    logic [NUM_OUT-1:0] rstOut;
    logic               rstDoneOut;
`ifdef RST_CAUSE_EN
    cause_e             causeOut;

    modport master (output extReqIn, swReqIn, input rstOut, rstDoneOut, causeOut);
    modport slave  (input extReqIn, swReqIn, output rstOut, rstDoneOut, causeOut);
`else
    modport master (output extReqIn, swReqIn, input rstOut, rstDoneOut);
    modport slave  (input extReqIn, swReqIn, output rstOut, rstDoneOut);
`endif
endinterface

// File: rtl/reset_sequencer_req_sync.sv
// -----------------------------------------------------------------------------
// req_sync
// STAGES-deep flop chain bringing an asynchronous level onto clkIn.
//   clkIn : destination clock
//   rstIn : synchronous active-low clear of the whole chain
//   dIn   : asynchronous input level
//   qOut  : synchronized level, follows dIn after STAGES edges
// -----------------------------------------------------------------------------
module req_sync #(
    parameter int STAGES = 2
) (
    input  logic clkIn,
    input  logic rstIn,
    input  logic dIn,
    output logic qOut
);
    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], dIn};
        end
    end

    assign qOut = chain_q[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Merges the block reset, a synchronized external request and a software
// pulse into NUM_OUT staged reset outputs. All outputs stay asserted until
// STRETCH_CYCLES quiet cycles have passed, then release one by one every
// STAGE_DELAY cycles (bit 0 first). Any request while releasing or released
// re-asserts everything and restarts the stretch.
// Ports:
//   clkIn : block clock
//   rstIn : synchronous active-low reset
//   bus   : reset_sequencer_if.slave (extReqIn, swReqIn, rstOut, rstDoneOut,
//           causeOut when RST_CAUSE_EN is defined)
// Optional feature macro: RST_CAUSE_EN (adds registered causeOut).
//
// state   | meaning
// HOLD    | all outputs asserted, counting quiet cycles toward the stretch
// RELEASE | releasing outputs in order, STAGE_DELAY cycles apart
// DONE    | all outputs released, rstDoneOut high
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int   NUM_OUT          = 3,
    parameter int   SYNC_STAGES      = 2,
    parameter int   STRETCH_CYCLES   = 16,
    parameter int   STAGE_DELAY      = 4,
    parameter logic RST_OUT_POLARITY = 1'b1
) (
    input  logic             clkIn,
    input  logic             rstIn,
    reset_sequencer_if.slave bus
);
    if (NUM_OUT < NUM_OUT_MIN || NUM_OUT > NUM_OUT_MAX) begin : g_bad_num_out
        $error("reset_sequencer: NUM_OUT out of range");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES out of range");
    end
    if (STRETCH_CYCLES < STRETCH_MIN || STRETCH_CYCLES > STRETCH_MAX) begin : g_bad_stretch
        $error("reset_sequencer: STRETCH_CYCLES out of range");
    end
    if (STAGE_DELAY < 0 || STAGE_DELAY > STAGE_DELAY_MAX) begin : g_bad_delay
        $error("reset_sequencer: STAGE_DELAY out of range");
    end

    localparam int STR_W = cnt_width(STRETCH_CYCLES + 1);
    localparam int DLY_W = cnt_width(STAGE_DELAY + 1);
    localparam int IDX_W = cnt_width(NUM_OUT);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((STAGE_DELAY == 0) ? 0 : STAGE_DELAY - 1);
    // Whole release collapses into the HOLD exit edge.
    localparam bit ALL_AT_ONCE = (STAGE_DELAY == 0) || (NUM_OUT == 1);

    seq_state_e         state_q, state_d;
    logic [STR_W-1:0]   str_q, str_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [NUM_OUT-1:0] rel_q, rel_d;      // 1 = output released
    logic               done_q, done_d;
    logic               sync_req, any_req, enter_hold;

    req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .dIn   (bus.extReqIn),
        .qOut  (sync_req)
    );

    assign any_req = sync_req | bus.swReqIn;
    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        str_d      = str_q;
        dly_d      = dly_q;
        idx_d      = idx_q;
        rel_d      = rel_q;
        done_d     = done_q;
        enter_hold = 1'b0;
        unique case (state_q)
            HOLD: begin
                if (any_req) begin
                    str_d = '0;
                end else if (str_q == STR_LAST) begin
                    str_d = '0;
                    dly_d = '0;
                    idx_d = '0;
                    if (ALL_AT_ONCE) begin
                        rel_d   = '1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rel_d   = NUM_OUT'(1);
                        state_d = RELEASE;
                    end
                end else begin
                    str_d = str_q + 1'b1;
                end
            end
            RELEASE: begin
                if (any_req) begin
                    enter_hold = 1'b1;
                end else if (dly_q == DLY_LAST) begin
                    dly_d          = '0;
                    idx_d          = idx_nxt;
                    rel_d[idx_nxt] = 1'b1;
                    if (int'(idx_nxt) == NUM_OUT - 1) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            DONE: begin
                if (any_req) begin
                    enter_hold = 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase
        if (enter_hold) begin
            state_d = HOLD;
            str_d   = '0;
            rel_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            state_q <= HOLD;
            str_q   <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    assign bus.rstOut     = {NUM_OUT{RST_OUT_POLARITY}} ^ rel_q;
    assign bus.rstDoneOut = done_q;

`ifdef RST_CAUSE_EN
    cause_e cause_q, cause_d;

    // Only transitions into HOLD record a cause; new requests while already
    // holding leave the last recorded cause untouched.
    always_comb begin
        cause_d = cause_q;
        if (enter_hold) begin
            cause_d = cause_e'({bus.swReqIn, sync_req});
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            cause_q <= CAUSE_RST;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign bus.causeOut = cause_q;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    localparam int NK = 3;

    // Instance k: NUM_OUT, SYNC_STAGES, STRETCH_CYCLES, STAGE_DELAY, polarity
    function automatic int p_n(input int k);
        case (k) 0: return 3; 1: return 4; default: return 2; endcase
    endfunction
    function automatic int p_s(input int k);
        case (k) 0: return 2; 1: return 2; default: return 3; endcase
    endfunction
    function automatic int p_str(input int k);
        case (k) 0: return 16; 1: return 16; default: return 1; endcase
    endfunction
    function automatic int p_d(input int k);
        case (k) 0: return 4; 1: return 0; default: return 2; endcase
    endfunction
    function automatic logic p_pol(input int k);
        case (k) 0: return 1'b1; 1: return 1'b1; default: return 1'b0; endcase
    endfunction

    logic clkIn = 1'b0;
    logic rst_n;
    logic ext_req;
    logic sw_req;
    int   tests = 0;
    int   fails = 0;

    always #5 clkIn = ~clkIn;

    reset_sequencer_if #(.NUM_OUT(3)) if0 ();
    reset_sequencer_if #(.NUM_OUT(4)) if1 ();
    reset_sequencer_if #(.NUM_OUT(2)) if2 ();

    assign if0.extReqIn = ext_req;
    assign if0.swReqIn  = sw_req;
    assign if1.extReqIn = ext_req;
    assign if1.swReqIn  = sw_req;
    assign if2.extReqIn = ext_req;
    assign if2.swReqIn  = sw_req;

    reset_sequencer #(.NUM_OUT(3), .SYNC_STAGES(2), .STRETCH_CYCLES(16),
                      .STAGE_DELAY(4), .RST_OUT_POLARITY(1'b1)) dut0 (
        .clkIn (clkIn), .rstIn (rst_n), .bus (if0));
    reset_sequencer #(.NUM_OUT(4), .SYNC_STAGES(2), .STRETCH_CYCLES(16),
                      .STAGE_DELAY(0), .RST_OUT_POLARITY(1'b1)) dut1 (
        .clkIn (clkIn), .rstIn (rst_n), .bus (if1));
    reset_sequencer #(.NUM_OUT(2), .SYNC_STAGES(3), .STRETCH_CYCLES(1),
                      .STAGE_DELAY(2), .RST_OUT_POLARITY(1'b0)) dut2 (
        .clkIn (clkIn), .rstIn (rst_n), .bus (if2));

    // Model: q[k] = number of consecutive edges with rstIn high and no request.
    // Output bit i is released once q >= STRETCH + i*DELAY.
    logic [3:0] sh = 4'b0;
    int         q [NK];
    logic [1:0] cause_m [NK];
    bit         model_ok = 1'b0;

    always @(posedge clkIn) begin
        logic sync_v;
        logic any_v;
        logic was_rel;
        for (int k = 0; k < NK; k++) begin
            sync_v  = sh[p_s(k) - 1];
            any_v   = sync_v | sw_req;
            was_rel = (q[k] >= p_str(k));
            if (!rst_n) begin
                q[k]       = 0;
                cause_m[k] = 2'b00;
            end else if (any_v) begin
                if (was_rel) cause_m[k] = {sw_req, sync_v};
                q[k] = 0;
            end else if (q[k] < 1000000) begin
                q[k] = q[k] + 1;
            end
        end
        sh = rst_n ? {sh[2:0], ext_req} : 4'b0;
        if (!rst_n) model_ok = 1'b1;
    end

    function automatic logic [7:0] exp_out(input int k);
        logic [7:0] v;
        logic       rel;
        v = 8'h00;
        for (int i = 0; i < p_n(k); i++) begin
            rel  = (q[k] >= p_str(k) + i * p_d(k));
            v[i] = rel ? ~p_pol(k) : p_pol(k);
        end
        return v;
    endfunction

    function automatic logic exp_done(input int k);
        return q[k] >= p_str(k) + (p_n(k) - 1) * p_d(k);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clkIn) begin
        if (model_ok) begin
            check("dut0.rstOut", 8'(if0.rstOut), exp_out(0));
            check("dut0.rstDoneOut", 8'(if0.rstDoneOut), 8'(exp_done(0)));
            check("dut1.rstOut", 8'(if1.rstOut), exp_out(1));
            check("dut1.rstDoneOut", 8'(if1.rstDoneOut), 8'(exp_done(1)));
            check("dut2.rstOut", 8'(if2.rstOut), exp_out(2));
            check("dut2.rstDoneOut", 8'(if2.rstDoneOut), 8'(exp_done(2)));
`ifdef RST_CAUSE_EN
            check("dut0.causeOut", 8'(if0.causeOut), 8'(cause_m[0]));
            check("dut1.causeOut", 8'(if1.causeOut), 8'(cause_m[1]));
            check("dut2.causeOut", 8'(if2.causeOut), 8'(cause_m[2]));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clkIn);
        #1;
    endtask

    task automatic pin_cause(input string name, input logic [1:0] exp);
`ifdef RST_CAUSE_EN
        check(name, 8'(if0.causeOut), 8'(exp));
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        ext_req = 1'b0;
        sw_req  = 1'b0;
        step(5);
        check("reset rstOut", 8'(if0.rstOut), 8'h07);
        check("reset rstDone", 8'(if0.rstDoneOut), 8'h00);
        check("reset dut2 rstOut", 8'(if2.rstOut), 8'h00);
        pin_cause("reset cause", 2'b00);
        rst_n = 1'b1;

        // Power-on release timeline, edges counted from the first quiet edge
        for (int e = 1; e <= 24; e++) begin
            step(1);
            case (e)
                1:  check("dut2 edge1", 8'(if2.rstOut), 8'h01);
                3: begin
                    check("dut2 edge3", 8'(if2.rstOut), 8'h03);
                    check("dut2 done edge3", 8'(if2.rstDoneOut), 8'h01);
                end
                15: begin
                    check("edge15", 8'(if0.rstOut), 8'h07);
                    check("dut1 edge15", 8'(if1.rstOut), 8'h0f);
                end
                16: begin
                    check("edge16", 8'(if0.rstOut), 8'h06);
                    check("dut1 edge16", 8'(if1.rstOut), 8'h00);
                    check("dut1 done edge16", 8'(if1.rstDoneOut), 8'h01);
                    check("done edge16", 8'(if0.rstDoneOut), 8'h00);
                end
                20: check("edge20", 8'(if0.rstOut), 8'h04);
                24: begin
                    check("edge24", 8'(if0.rstOut), 8'h00);
                    check("done edge24", 8'(if0.rstDoneOut), 8'h01);
                end
                default: ;
            endcase
        end

        // Software pulse from DONE
        step(3);
        sw_req = 1'b1;
        step(1);
        sw_req = 1'b0;
        check("sw reassert", 8'(if0.rstOut), 8'h07);
        check("sw done clear", 8'(if0.rstDoneOut), 8'h00);
        pin_cause("sw cause", 2'b10);
        step(15);
        check("sw edge15", 8'(if0.rstOut), 8'h07);
        step(1);
        check("sw edge16", 8'(if0.rstOut), 8'h06);
        step(8);
        check("sw edge24", 8'(if0.rstOut), 8'h00);

        // External request for 10 cycles
        ext_req = 1'b1;
        step(2);
        check("ext not yet", 8'(if0.rstOut), 8'h00);
        step(1);
        check("ext reassert", 8'(if0.rstOut), 8'h07);
        pin_cause("ext cause", 2'b01);
        step(7);
        ext_req = 1'b0;
        step(17);
        check("ext hold last", 8'(if0.rstOut), 8'h07);
        step(1);
        check("ext release0", 8'(if0.rstOut), 8'h06);

        // rstIn low mid-release, then a request in the last count cycle
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rst midrelease", 8'(if0.rstOut), 8'h07);
        pin_cause("rst cause", 2'b00);
        step(15);
        sw_req = 1'b1;
        step(3);
        sw_req = 1'b0;
        check("late req blocks", 8'(if0.rstOut), 8'h07);
        step(15);
        check("level sw hold", 8'(if0.rstOut), 8'h07);
        step(1);
        check("level sw release", 8'(if0.rstOut), 8'h06);
        pin_cause("hold keeps cause", 2'b00);

        // Both requests in the same cycle, then a later sw-only pulse
        step(8);
        check("done again", 8'(if0.rstOut), 8'h00);
        ext_req = 1'b1;
        step(2);
        sw_req = 1'b1;
        step(1);
        sw_req  = 1'b0;
        ext_req = 1'b0;
        pin_cause("both cause", 2'b11);
        step(45);
        sw_req = 1'b1;
        step(1);
        sw_req = 1'b0;
        pin_cause("sw cause again", 2'b10);
        step(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the two-flop reset synchronizer.
- Combines reset sources into NUM_OUT staged reset outputs on one clock domain:
  - the synchronous block reset,
  - an asynchronous external reset request, synchronized internally,
  - a software reset pulse.
- Guarantees a minimum assertion time, then releases the outputs in order, e.g. core, then bus, then peripherals.
- Sits at the top of each clock domain, feeding downstream resets.

Parameters:
- NUM_OUT, 3: number of staged reset outputs (1..8).
- SYNC_STAGES, 2: flop depth of the extReqIn synchronizer (2..4).
- STRETCH_CYCLES, 16: minimum cycles all outputs stay asserted after the last request drops (1..65535).
- STAGE_DELAY, 4: cycles between successive output releases (0..255; 0 releases all outputs together).
- RST_OUT_POLARITY, 1'b1: asserted level of rstOut bits.

Ports:
- clkIn, input, 1: block clock.
- rstIn, input, 1: synchronous, active-low reset.
- extReqIn, input, 1: asynchronous level reset request, active-high.
- swReqIn, input, 1: synchronous single-cycle software reset pulse, active-high.
- rstOut, output, NUM_OUT: staged resets; bit 0 releases first.
- rstDoneOut, output, 1: high when all outputs are released.

Behaviour:
- Reset (rstIn sampled low at a clkIn edge):
  - state = HOLD, counters cleared, synchronizer flops cleared to 0;
  - every rstOut bit = RST_OUT_POLARITY, rstDoneOut = 0.
- reqSync: extReqIn passed through SYNC_STAGES flops. A change at extReqIn is visible after SYNC_STAGES edges.
- anyReq = reqSync | swReqIn.
- States:
  - HOLD:
    - all outputs asserted;
    - stretch counter cleared each cycle anyReq = 1;
    - when anyReq = 0, counter increments;
    - when counter reaches STRETCH_CYCLES-1 with anyReq = 0, go to RELEASE with stage index 0 and stage counter 0.
  - RELEASE:
    - on entry edge, rstOut[0] deasserts;
    - each further STAGE_DELAY cycles, the next bit deasserts;
    - with STAGE_DELAY = 0, all bits deassert on the entry edge;
    - when bit NUM_OUT-1 deasserts, go to DONE and set rstDoneOut on that same edge.
  - DONE: all outputs deasserted, rstDoneOut = 1.
- Release timing: first edge with rstIn high and no requests is cycle 1.
  - rstOut[i] changes at the edge ending cycle STRETCH_CYCLES + i*STAGE_DELAY.
  - Defaults: bits release at edges 16, 20 and 24; rstDoneOut rises at edge 24.
- Re-entry:
  - anyReq = 1 in RELEASE or DONE goes to HOLD on the next edge;
  - all outputs re-assert and rstDoneOut clears on that same edge;
  - the stretch count restarts.
- Boundary cases:
  - anyReq in the last HOLD count cycle prevents the release.
  - swReqIn held more than one cycle acts as a level.
  - rstIn low overrides everything in any state, including mid-release.
- Outputs are registered; there is no combinational path from any input to rstOut.
- Counter widths: $clog2(STRETCH_CYCLES+1), $clog2(STAGE_DELAY+1) (minimum 1), $clog2(NUM_OUT).

Optional Feature:
- Macro RST_CAUSE_EN.
- When defined, adds output causeOut[1:0]:
  - registered cause of the most recent entry into HOLD: 2'b00 rstIn, 2'b01 external request, 2'b10 software request, 2'b11 both requests in the same cycle;
  - written on the edge of HOLD entry, held until the next entry;
  - reset value 2'b00.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants HOLD = 2'd0, RELEASE = 2'd1, DONE = 2'd2;
  - cause codes;
  - parameter range-check constants.
- Sub-module req_sync:
  - SYNC_STAGES-deep flop chain with synchronous active-low clear;
  - reusable by other blocks.

Test Plan:
- Defaults; rstIn low 5 cycles, then high -> rstOut = 3'b111 through edge 15; 3'b110 at edge 16; 3'b100 at 20; 3'b000 at 24; rstDoneOut rises at edge 24.
- In DONE, pulse swReqIn for 1 cycle -> next edge rstOut = 3'b111 and rstDoneOut = 0; release repeats 16/20/24 cycles after the pulse cycle.
- In DONE, raise extReqIn for 10 cycles -> outputs assert 2+1 edges later; release bit 0 16 cycles after reqSync falls.
- Set STAGE_DELAY = 0, NUM_OUT = 4 -> all four bits deassert together at edge 16; rstDoneOut rises at the same edge.
- During RELEASE with rstOut = 3'b110, drive rstIn low for 1 cycle -> rstOut = 3'b111 next edge; the full stretch restarts.
- With RST_CAUSE_EN defined, assert swReqIn and reqSync in the same cycle -> causeOut = 2'b11; a later sw-only pulse -> 2'b10.
